census_frame_seq: RTL and testbench

//  Frame sequencer for the 3x3 census engine. On start, it clears the engine
//  and streams one WxH 8-bit gray frame from a frame-buffer read port into the

---
 rtl/census_pkg.sv | 12 +
 rtl/census_addr_gen.sv | 26 ++
 rtl/census_frame_seq.sv | 129 ++++++++++++
 tb/tb_census_frame_seq.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/census_pkg.sv
// Shared types and helpers for the census frame sequencer.
package census_pkg;

  typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, DONE} seq_state_t;

  localparam int unsigned CENSUS_DRAIN_DEFAULT = 3;

  function automatic int unsigned census_addr_w(input int unsigned pixels);
    return (pixels > 1) ? $clog2(pixels) : 1;
  endfunction

endpackage

// File: rtl/census_addr_gen.sv
// Linear frame-buffer address counter; parks on the last address until cleared.
module census_addr_gen #(
  parameter int unsigned DEPTH  = 76800,
  parameter int unsigned ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              en,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  assign last = (addr == LAST_ADDR);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      addr <= '0;
    end else if (en && !last) begin
      addr <= addr + 1'b1;
    end
  end

endmodule

// File: rtl/census_frame_seq.sv
// Frame sequencer: clears the census engine, streams one frame, drains, reports done.
// Optional CENSUS_SEQ_STATS_EN adds frame_cycles/stall_cycles counters.
module census_frame_seq
  import census_pkg::*;
#(
  parameter int unsigned IMAGE_WIDTH  = 320,
  parameter int unsigned IMAGE_HEIGHT = 240,
  parameter int unsigned DRAIN_CYCLES = CENSUS_DRAIN_DEFAULT,
  parameter int unsigned ADDR_W       = census_addr_w(IMAGE_WIDTH * IMAGE_HEIGHT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              hold,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              eng_rst,
  output logic              gray_valid,
  output logic [7:0]        gray,
  input  logic              census_valid,
  output logic [31:0]       out_count
`ifdef CENSUS_SEQ_STATS_EN
  ,
  output logic [31:0]       frame_cycles,
  output logic [31:0]       stall_cycles
`endif
);

  localparam int unsigned DCW = $clog2(DRAIN_CYCLES + 2);
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_CYCLES);

  seq_state_t     state, next;
  logic           last;
  logic [DCW-1:0] drain_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next;
    end
  end

  always_comb begin
    next    = state;
    busy    = (state != IDLE);
    done    = 1'b0;
    eng_rst = 1'b0;
    rd_en   = 1'b0;
    case (state)
      IDLE:   if (start) next = CLEAR;
      CLEAR: begin
        eng_rst = 1'b1;
        next    = STREAM;
      end
      STREAM: begin
        rd_en = !hold;
        if (!hold && last) next = DRAIN;
      end
      DRAIN:  if (drain_cnt == DRAIN_LAST) next = DONE;
      DONE: begin
        done = 1'b1;
        next = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  census_addr_gen #(
    .DEPTH  (IMAGE_WIDTH * IMAGE_HEIGHT),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk   (clk),
    .rst   (rst),
    .clear (state == CLEAR),
    .en    (rd_en),
    .addr  (rd_addr),
    .last  (last)
  );

  always_ff @(posedge clk) begin
    if (rst || state != DRAIN) begin
      drain_cnt <= '0;
    end else if (drain_cnt != DRAIN_LAST) begin
      drain_cnt <= drain_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gray_valid <= 1'b0;
    end else begin
      gray_valid <= rd_en;
    end
  end

  // The read port already registers its data one cycle after rd_en, which is
  // exactly the gray_valid cycle; gating keeps gray at 0 outside beats.
  assign gray = gray_valid ? rd_data : '0;

  always_ff @(posedge clk) begin
    if (rst || state == CLEAR) begin
      out_count <= '0;
    end else if ((state == STREAM || state == DRAIN) && census_valid && out_count != '1) begin
      out_count <= out_count + 1'b1;
    end
  end

`ifdef CENSUS_SEQ_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cycles <= '0;
      stall_cycles <= '0;
    end else if (state == CLEAR) begin
      frame_cycles <= 32'd1;
      stall_cycles <= '0;
    end else if (state != IDLE) begin
      frame_cycles <= frame_cycles + 1'b1;
      if (state == STREAM && hold) begin
        stall_cycles <= stall_cycles + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_census_frame_seq.sv
// Directed self-checking bench for census_frame_seq on a 4x3 frame.
module tb_census_frame_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        hold = 1'b0;
  logic        busy, done, rd_en, eng_rst, gray_valid;
  logic [3:0]  rd_addr;
  logic [7:0]  rd_data = 8'h00;
  logic [7:0]  gray;
  logic        census_valid = 1'b0;
  logic [31:0] out_count;
`ifdef CENSUS_SEQ_STATS_EN
  logic [31:0] frame_cycles, stall_cycles;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int s;
  int gap;

  int beat_val[$];
  int beat_cyc[$];
  int addr_q[$];
  int done_q[$];
  int eng_q[$];
  int n_busy;

  census_frame_seq #(
    .IMAGE_WIDTH  (4),
    .IMAGE_HEIGHT (3),
    .DRAIN_CYCLES (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .hold         (hold),
    .busy         (busy),
    .done         (done),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .eng_rst      (eng_rst),
    .gray_valid   (gray_valid),
    .gray         (gray),
    .census_valid (census_valid),
    .out_count    (out_count)
`ifdef CENSUS_SEQ_STATS_EN
    ,
    .frame_cycles (frame_cycles),
    .stall_cycles (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Frame memory: registered read, data = addr + 0x10.
  always @(posedge clk) if (rd_en) rd_data <= {4'h0, rd_addr} + 8'h10;

  always @(negedge clk) begin
    if (gray_valid) begin
      beat_val.push_back(int'(gray));
      beat_cyc.push_back(cyc);
    end
    if (rd_en)   addr_q.push_back(int'(rd_addr));
    if (done)    done_q.push_back(cyc);
    if (eng_rst) eng_q.push_back(cyc);
    if (busy)    n_busy++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    beat_val.delete();
    beat_cyc.delete();
    addr_q.delete();
    done_q.delete();
    eng_q.delete();
    n_busy = 0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_rd_en"}, rd_en, 1'b0);
    chk({tag, "_eng_rst"}, eng_rst, 1'b0);
    chk({tag, "_gray_valid"}, gray_valid, 1'b0);
    chk({tag, "_rd_addr"}, rd_addr, 4'd0);
    chk({tag, "_gray"}, gray, 8'h00);
    chk({tag, "_out_count"}, out_count, 32'd0);
  endtask

  // Drives one frame cycle by cycle; k is the offset from the start cycle.
  task automatic run_frame(input int hold_at, input int hold_len,
                           input logic [63:0] cv, input logic [63:0] st,
                           output int s0);
    clear_logs();
    s0 = cyc;
    for (int k = 0; k < 60; k++) begin
      start        = st[k];
      hold         = (k >= hold_at) && (k < hold_at + hold_len);
      census_valid = cv[k];
      step(1);
      if (done_q.size() > 0) break;
    end
    start        = 1'b0;
    hold         = 1'b0;
    census_valid = 1'b0;
    chk("frame_done_seen", done_q.size(), 32'd1);
  endtask

  initial begin
    step(3);
    check_idle("reset");
    rst = 1'b0;
    step(2);

    // Plain frame with census pulses in STREAM/DRAIN plus one in DONE.
    run_frame(0, 0, 64'h0000_0000_0004_9048, 64'h1, s);
    chk("s1_done_at", done_q[0] - s, 32'd18);
    chk("s1_busy_cycles", n_busy, 32'd18);
    chk("s1_eng_rst_count", eng_q.size(), 32'd1);
    if (eng_q.size() > 0) chk("s1_eng_rst_at", eng_q[0] - s, 32'd1);
    chk("s1_beats", beat_val.size(), 32'd12);
    for (int i = 0; i < 12 && i < beat_val.size(); i++) begin
      chk($sformatf("s1_beat_val%0d", i), beat_val[i], 32'h10 + i);
      chk($sformatf("s1_beat_cyc%0d", i), beat_cyc[i] - s, 32'd3 + i);
    end
    chk("s2_out_count_done", out_count, 32'd4);
    census_valid = 1'b1;
    step(1);
    census_valid = 1'b0;
    step(1);
    chk("s2_out_count_idle", out_count, 32'd4);
    chk("s2_busy_idle", busy, 1'b0);

    // Hold for 3 cycles right after the 5th read.
    run_frame(7, 3, 64'h0, 64'h1, s);
    chk("s3_done_at", done_q[0] - s, 32'd21);
    chk("s3_beats", beat_val.size(), 32'd12);
    chk("s3_addrs", addr_q.size(), 32'd12);
    for (int i = 0; i < 12 && i < beat_val.size(); i++)
      chk($sformatf("s3_beat_val%0d", i), beat_val[i], 32'h10 + i);
    for (int i = 0; i < 12 && i < addr_q.size(); i++)
      chk($sformatf("s3_addr%0d", i), addr_q[i], i);
    if (beat_cyc.size() == 12) begin
      chk("s3_trailing_beat_at", beat_cyc[4] - s, 32'd7);
      chk("s3_resume_beat_at", beat_cyc[5] - s, 32'd11);
      chk("s3_last_beat_at", beat_cyc[11] - s, 32'd17);
    end
    gap = 0;
    foreach (beat_cyc[i]) if (beat_cyc[i] - s >= 8 && beat_cyc[i] - s <= 10) gap++;
    chk("s3_gap_beats", gap, 32'd0);
    chk("s3_out_count_cleared", out_count, 32'd0);
    chk("s3_rd_addr_parked", rd_addr, 4'd11);
`ifdef CENSUS_SEQ_STATS_EN
    chk("s6_frame_cycles", frame_cycles, 32'd21);
    chk("s6_stall_cycles", stall_cycles, 32'd3);
`endif

    // start pulsed in STREAM (k=5) and in DONE (k=18) is ignored.
    run_frame(0, 0, 64'h0, 64'h0000_0000_0004_0021, s);
    chk("s4_done_at", done_q[0] - s, 32'd18);
    chk("s4_eng_rst_count", eng_q.size(), 32'd1);
    step(4);
    chk("s4_done_pulses", done_q.size(), 32'd1);
    chk("s4_busy_after", busy, 1'b0);

    // start held high: back-to-back frames.
    clear_logs();
    s = cyc;
    start = 1'b1;
    for (int k = 0; k < 80 && done_q.size() < 2; k++) step(1);
    start = 1'b0;
    chk("s4_b2b_done_count", done_q.size(), 32'd2);
    if (done_q.size() == 2) begin
      chk("s4_b2b_done0_at", done_q[0] - s, 32'd18);
      chk("s4_b2b_done1_at", done_q[1] - s, 32'd37);
    end
    chk("s4_b2b_eng_rst_count", eng_q.size(), 32'd2);
    if (eng_q.size() == 2) chk("s4_b2b_eng_rst1_at", eng_q[1] - s, 32'd20);
    step(3);

    // Reset mid-stream at address 7.
    clear_logs();
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(8);
    chk("s5_addr_before_rst", rd_addr, 4'd7);
    rst = 1'b1;
    step(1);
    check_idle("s5_after_rst");
    rst = 1'b0;
    clear_logs();
    step(20);
    chk("s5_no_done", done_q.size(), 32'd0);
    chk("s5_no_busy", n_busy, 32'd0);
    run_frame(0, 0, 64'h0, 64'h1, s);
    chk("s5_restart_done_at", done_q[0] - s, 32'd18);
    chk("s5_restart_addrs", addr_q.size(), 32'd12);
    if (addr_q.size() > 0) chk("s5_restart_addr0", addr_q[0], 32'd0);
    if (beat_val.size() > 0) chk("s5_restart_beat0", beat_val[0], 32'h10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
